ram_pattern_checker: RTL

Synthesizable traffic generator and checker for the RAM IP simulation bench. It sits directly downstream of the bench clock/reset generator and consumes its clock and active-low reset. It drives the RAM under test's write and read ports with a deterministic address-derived pattern, then compares read-back data over a configurable read latency. It reports done, pass/fail, an error count and the first failing address.

---
 rtl/ram_pattern_checker.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ram_pattern_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ram_pattern_checker
// Purpose  : Traffic generator and checker for a RAM under test. Writes an
//            address-derived pattern to every word, reads every word back,
//            and compares the returned data over a fixed read latency.
//            Repeats for NUM_PASSES passes, alternating the pattern mask,
//            then reports done / pass, a saturating error count and the
//            address of the first mismatch.
// Ports    : clk_i            bench clock (rising edge)
//            rst_n_i          asynchronous active-low reset
//            start_i          run request (honoured in IDLE and DONE only)
//            wr_en_o          RAM write enable
//            wr_addr_o        RAM write address
//            wr_data_o        RAM write data
//            rd_en_o          RAM read enable
//            rd_addr_o        RAM read address
//            rd_data_i        RAM read data, valid RD_LATENCY cycles after rd_en_o
//            busy_o           run in progress (WRITE, READ, DRAIN)
//            done_o           run finished, results held
//            pass_o           run finished with no mismatches
//            err_count_o      mismatch count, saturating at 16'hFFFF
//            first_err_addr_o address of the first mismatch of the run
// Revision : 1.0 - initial release
// ============================================================================
module ram_pattern_checker #(
  parameter int          ADDR_WIDTH = 9,
  parameter int          DATA_WIDTH = 16,
  parameter int          RD_LATENCY = 2,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          NUM_PASSES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [15:0]           err_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [PASS_W-1:0]     LAST_PASS  = PASS_W'(NUM_PASSES - 1);
  localparam logic [LAT_W-1:0]      LAST_DRAIN = LAT_W'(RD_LATENCY - 1);
  // Seed truncated or zero-extended to the data width.
  localparam logic [DATA_WIDTH-1:0] MASK       = DATA_WIDTH'(SEED);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Address replicated from the LSB upwards (equivalent to {a,a,...}
  // truncated to DATA_WIDTH), XOR the seed on even passes and its
  // complement on odd passes.
  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  odd_pass
  );
    logic [DATA_WIDTH-1:0] rep;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      rep[i] = addr[i % ADDR_WIDTH];
    end
    return rep ^ (odd_pass ? ~MASK : MASK);
  endfunction

  state_t                state_q, state_d;
  logic [PASS_W-1:0]     pass_idx_q, pass_idx_d;
  logic [LAT_W-1:0]      drain_q, drain_d;

  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  // Expected data for the read currently on rd_addr_o; travels with it.
  logic [DATA_WIDTH-1:0] rd_exp_q, rd_exp_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_ok_q, pass_ok_d;
  logic [15:0]           err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;

  // Compare pipeline. Stage 0 is loaded at the edge that ends the rd_en_o
  // cycle, so the last stage lines up with the edge at which the RAM data
  // for that read is valid.
  logic [RD_LATENCY-1:0]                 pipe_v_q, pipe_v_d;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] pipe_addr_q, pipe_addr_d;
  logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] pipe_exp_q, pipe_exp_d;

  logic                  cmp_mismatch;

  assign cmp_mismatch = pipe_v_q[RD_LATENCY-1] &&
                        (rd_data_i != pipe_exp_q[RD_LATENCY-1]);

  always_comb begin
    pipe_v_d       = pipe_v_q;
    pipe_addr_d    = pipe_addr_q;
    pipe_exp_d     = pipe_exp_q;
    pipe_v_d[0]    = rd_en_q;
    pipe_addr_d[0] = rd_addr_q;
    pipe_exp_d[0]  = rd_exp_q;
    for (int j = 1; j < RD_LATENCY; j++) begin
      pipe_v_d[j]    = pipe_v_q[j-1];
      pipe_addr_d[j] = pipe_addr_q[j-1];
      pipe_exp_d[j]  = pipe_exp_q[j-1];
    end
  end

  always_comb begin
    state_d          = state_q;
    pass_idx_d       = pass_idx_q;
    drain_d          = drain_q;
    wr_en_d          = 1'b0;
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
    rd_en_d          = 1'b0;
    rd_addr_d        = rd_addr_q;
    rd_exp_d         = rd_exp_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;

    if (cmp_mismatch) begin
      if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end
      if (err_count_q == 16'd0) begin
        first_err_addr_d = pipe_addr_q[RD_LATENCY-1];
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          err_count_d      = 16'd0;
          first_err_addr_d = '0;
          pass_idx_d       = '0;
          state_d          = S_WRITE;
          wr_en_d          = 1'b1;
          wr_addr_d        = '0;
          wr_data_d        = pattern('0, 1'b0);
        end
      end

      S_WRITE: begin
        if (wr_addr_q == LAST_ADDR) begin
          state_d   = S_READ;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          rd_exp_d  = pattern('0, pass_idx_q[0]);
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          wr_data_d = pattern(wr_addr_q + 1'b1, pass_idx_q[0]);
        end
      end

      S_READ: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          rd_exp_d  = pattern(rd_addr_q + 1'b1, pass_idx_q[0]);
        end
      end

      S_DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          if (pass_idx_q != LAST_PASS) begin
            pass_idx_d = pass_idx_q + 1'b1;
            state_d    = S_WRITE;
            wr_en_d    = 1'b1;
            wr_addr_d  = '0;
            wr_data_d  = pattern('0, ~pass_idx_q[0]);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs track the state being entered. pass uses the count
    // after this edge's compare, which is the final compare of the run.
    busy_d    = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
    pass_ok_d = (state_d == S_DONE) && (err_count_d == 16'd0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q          <= S_IDLE;
      pass_idx_q       <= '0;
      drain_q          <= '0;
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      rd_en_q          <= 1'b0;
      rd_addr_q        <= '0;
      rd_exp_q         <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_ok_q        <= 1'b0;
      err_count_q      <= 16'd0;
      first_err_addr_q <= '0;
      pipe_v_q         <= '0;
      pipe_addr_q      <= '0;
      pipe_exp_q       <= '0;
    end else begin
      state_q          <= state_d;
      pass_idx_q       <= pass_idx_d;
      drain_q          <= drain_d;
      wr_en_q          <= wr_en_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
      rd_en_q          <= rd_en_d;
      rd_addr_q        <= rd_addr_d;
      rd_exp_q         <= rd_exp_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_ok_q        <= pass_ok_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      pipe_v_q         <= pipe_v_d;
      pipe_addr_q      <= pipe_addr_d;
      pipe_exp_q       <= pipe_exp_d;
    end
  end

  assign wr_en_o          = wr_en_q;
  assign wr_addr_o        = wr_addr_q;
  assign wr_data_o        = wr_data_q;
  assign rd_en_o          = rd_en_q;
  assign rd_addr_o        = rd_addr_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_ok_q;
  assign err_count_o      = err_count_q;
  assign first_err_addr_o = first_err_addr_q;

endmodule
`default_nettype wire
